// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory stage: FSM encoding, default width
// and the MEM/WB control bubble.
package riscv_pkg;

   localparam int unsigned DataWDefault = 64;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } lsu_state_e;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic [4:0] rd;
   } mw_ctrl_t;

   localparam mw_ctrl_t MwCtrlBubble = '{regwrite: 1'b0, memtoreg: 1'b0, rd: 5'd0};

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/acknowledge data-memory port between the memory stage and data memory.
interface mem_stage_lsu_if #(
   parameter int unsigned DATA_W = 64
);
   logic              req;
   logic              we;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; bubble_i loads an all-zero (no write-back) entry.
module mem_wb_reg
   import riscv_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bubble_i,
   input  mw_ctrl_t          ctrl_i,
   input  logic [DATA_W-1:0] read_data_i,
   input  logic [DATA_W-1:0] result_i,
   output mw_ctrl_t          ctrl_o,
   output logic [DATA_W-1:0] read_data_o,
   output logic [DATA_W-1:0] result_o
);

   mw_ctrl_t          ctrl_q;
   logic [DATA_W-1:0] read_data_q;
   logic [DATA_W-1:0] result_q;

   always_ff @(posedge clk) begin
      if (!reset || bubble_i) begin
         ctrl_q      <= MwCtrlBubble;
         read_data_q <= '0;
         result_q    <= '0;
      end else begin
         ctrl_q      <= ctrl_i;
         read_data_q <= read_data_i;
         result_q    <= result_i;
      end
   end

   assign ctrl_o      = ctrl_q;
   assign read_data_o = read_data_q;
   assign result_o    = result_q;

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: issues data-memory requests, stalls the front end while one is
// outstanding, aborts on timeout, resolves branches and loads MEM/WB.
module mem_stage_lsu
   import riscv_pkg::*;
#(
   parameter int unsigned DATA_W         = DataWDefault,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              EM_Branch,
   input  logic              EM_MemRead,
   input  logic              EM_MemWrite,
   input  logic              EM_MemtoReg,
   input  logic              EM_RegWrite,
   input  logic              EM_Zero,
   input  logic              EM_addermuxselect,
   input  logic [4:0]        EM_RD,
   input  logic [DATA_W-1:0] EM_Adder2Out,
   input  logic [DATA_W-1:0] EM_Result,
   input  logic [DATA_W-1:0] EM_WriteData,
   mem_stage_lsu_if.master   dmem,
   output logic              stall,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              flush,
   output logic              mem_err,
   output logic              MW_RegWrite,
   output logic              MW_MemtoReg,
   output logic [4:0]        MW_RD,
   output logic [DATA_W-1:0] MW_ReadData,
   output logic [DATA_W-1:0] MW_Result
);

   localparam int unsigned      CntW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   lsu_state_e        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              req_q, we_q, err_q;
   logic [DATA_W-1:0] addr_q, wdata_q;

   logic access, illegal, timeout;
   logic stall_raw, bubble, use_rdata, issue, release_req, err_set;
   mw_ctrl_t ctrl_in, ctrl_out;

   assign access  = EM_MemRead | EM_MemWrite;
   assign illegal = (EM_MemRead & EM_MemWrite) | (EM_Result[2:0] != 3'b000);
   assign timeout = (cnt_q == CntLast);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (access && !illegal) state_d = StBusy;
         StBusy:  if (dmem.ack || timeout) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_raw   = 1'b0;
      bubble      = 1'b1;
      use_rdata   = 1'b0;
      issue       = 1'b0;
      release_req = 1'b0;
      err_set     = 1'b0;
      cnt_d       = cnt_q;
      case (state_q)
         StIdle: begin
            if (!access) begin
               bubble = 1'b0;
            end else if (illegal) begin
               err_set = 1'b1;
            end else begin
               stall_raw = 1'b1;
               issue     = 1'b1;
               cnt_d     = '0;
            end
         end
         StBusy: begin
            if (dmem.ack) begin
               bubble      = 1'b0;
               use_rdata   = EM_MemRead;
               release_req = 1'b1;
            end else if (timeout) begin
               err_set     = 1'b1;
               release_req = 1'b1;
            end else begin
               stall_raw = 1'b1;
               cnt_d     = cnt_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

   // Request fields are captured once at issue and held for the whole access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (err_set) err_q <= 1'b1;
         if (issue) begin
            req_q   <= 1'b1;
            we_q    <= EM_MemWrite;
            addr_q  <= EM_Result;
            wdata_q <= EM_WriteData;
         end else if (release_req) begin
            req_q <= 1'b0;
         end
      end
   end

   assign dmem.req   = req_q;
   assign dmem.we    = we_q;
   assign dmem.addr  = addr_q;
   assign dmem.wdata = wdata_q;
   assign mem_err    = err_q;

   assign stall         = reset & stall_raw;
   assign branch_taken  = reset & EM_Branch & (EM_addermuxselect ? ~EM_Zero : EM_Zero);
   assign flush         = branch_taken;
   assign branch_target = EM_Adder2Out;

   assign ctrl_in = '{regwrite: EM_RegWrite, memtoreg: EM_MemtoReg, rd: EM_RD};

   mem_wb_reg #(
      .DATA_W (DATA_W)
   ) u_mem_wb_reg (
      .clk         (clk),
      .reset       (reset),
      .bubble_i    (bubble),
      .ctrl_i      (ctrl_in),
      .read_data_i (use_rdata ? dmem.rdata : '0),
      .result_i    (EM_Result),
      .ctrl_o      (ctrl_out),
      .read_data_o (MW_ReadData),
      .result_o    (MW_Result)
   );

   assign MW_RegWrite = ctrl_out.regwrite;
   assign MW_MemtoReg = ctrl_out.memtoreg;
   assign MW_RD       = ctrl_out.rd;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: single-cycle vector table plus load, store,
// timeout and reset-during-access sequences.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        EM_Branch, EM_MemRead, EM_MemWrite, EM_MemtoReg, EM_RegWrite;
   logic        EM_Zero, EM_addermuxselect;
   logic [4:0]  EM_RD;
   logic [63:0] EM_Adder2Out, EM_Result, EM_WriteData;
   logic        stall, branch_taken, flush, mem_err;
   logic [63:0] branch_target;
   logic        MW_RegWrite, MW_MemtoReg;
   logic [4:0]  MW_RD;
   logic [63:0] MW_ReadData, MW_Result;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu_if #(.DATA_W(64)) dmem_bus ();

   mem_stage_lsu #(
      .DATA_W         (64),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .EM_Branch         (EM_Branch),
      .EM_MemRead        (EM_MemRead),
      .EM_MemWrite       (EM_MemWrite),
      .EM_MemtoReg       (EM_MemtoReg),
      .EM_RegWrite       (EM_RegWrite),
      .EM_Zero           (EM_Zero),
      .EM_addermuxselect (EM_addermuxselect),
      .EM_RD             (EM_RD),
      .EM_Adder2Out      (EM_Adder2Out),
      .EM_Result         (EM_Result),
      .EM_WriteData      (EM_WriteData),
      .dmem              (dmem_bus.master),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .flush             (flush),
      .mem_err           (mem_err),
      .MW_RegWrite       (MW_RegWrite),
      .MW_MemtoReg       (MW_MemtoReg),
      .MW_RD             (MW_RD),
      .MW_ReadData       (MW_ReadData),
      .MW_Result         (MW_Result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        br, mrd, mwr, mtr, rw, zero, ams;
      logic [4:0]  rd;
      logic [63:0] tgt, res, wd;
      logic        e_stall, e_bt, e_rw, e_mtr;
      logic [4:0]  e_rd;
      logic [63:0] e_res;
      logic        e_err;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic br, input logic mrd, input logic mwr, input logic mtr,
                        input logic rw, input logic zero, input logic ams, input logic [4:0] rd,
                        input logic [63:0] tgt, input logic [63:0] res, input logic [63:0] wd);
      EM_Branch = br; EM_MemRead = mrd; EM_MemWrite = mwr; EM_MemtoReg = mtr;
      EM_RegWrite = rw; EM_Zero = zero; EM_addermuxselect = ams; EM_RD = rd;
      EM_Adder2Out = tgt; EM_Result = res; EM_WriteData = wd;
   endtask

   task automatic set_nop();
      drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic check_mw_bubble(input string name);
      check({name, "_mw_rw"}, 64'(MW_RegWrite), 64'd0);
      check({name, "_mw_mtr"}, 64'(MW_MemtoReg), 64'd0);
      check({name, "_mw_rd"}, 64'(MW_RD), 64'd0);
      check({name, "_mw_rdata"}, MW_ReadData, 64'd0);
      check({name, "_mw_res"}, MW_Result, 64'd0);
   endtask

   int  stall_cnt;
   bit  done;

   initial begin
      //            br mrd mwr mtr rw z ams rd  tgt        res                     wd   st bt rw mtr rd  res                    err
      vecs[0] = '{0, 0, 0, 0, 1, 0, 0, 5'd5,  64'h0,   64'h2A,                 64'h0, 0, 0, 1, 0, 5'd5,  64'h2A,                0};
      vecs[1] = '{1, 0, 0, 0, 0, 1, 0, 5'd0,  64'h400, 64'h10,                 64'h0, 0, 1, 0, 0, 5'd0,  64'h10,                0};
      vecs[2] = '{1, 0, 0, 0, 0, 1, 1, 5'd0,  64'h400, 64'h10,                 64'h0, 0, 0, 0, 0, 5'd0,  64'h10,                0};
      vecs[3] = '{1, 0, 0, 0, 1, 0, 1, 5'd31, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1, 1, 0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0};
      vecs[4] = '{0, 0, 0, 1, 1, 1, 0, 5'd7,  64'h40,  64'h13,                 64'h0, 0, 0, 1, 1, 5'd7,  64'h13,                0};
      vecs[5] = '{0, 1, 0, 1, 1, 0, 0, 5'd9,  64'h0,   64'h103,                64'h0, 0, 0, 0, 0, 5'd0,  64'h0,                 1};
      vecs[6] = '{0, 1, 1, 0, 1, 0, 0, 5'd3,  64'h0,   64'h200,                64'h77, 0, 0, 0, 0, 5'd0,  64'h0,                 1};

      dmem_bus.ack   = 1'b0;
      dmem_bus.rdata = 64'd0;
      // Present a load and a taken branch during reset: both must be masked.
      drive(1, 1, 0, 1, 1, 1, 0, 5'd4, 64'h400, 64'h100, 64'h0);
      reset = 1'b0;
      tick();
      tick();
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_bt", 64'(branch_taken), 64'd0);
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_req", 64'(dmem_bus.req), 64'd0);
      check("rst_we", 64'(dmem_bus.we), 64'd0);
      check("rst_addr", dmem_bus.addr, 64'd0);
      check("rst_err", 64'(mem_err), 64'd0);
      check_mw_bubble("rst");
      set_nop();
      reset = 1'b1;

      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].br, vecs[i].mrd, vecs[i].mwr, vecs[i].mtr, vecs[i].rw, vecs[i].zero,
               vecs[i].ams, vecs[i].rd, vecs[i].tgt, vecs[i].res, vecs[i].wd);
         #1;
         check($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
         check($sformatf("v%0d_bt", i), 64'(branch_taken), 64'(vecs[i].e_bt));
         check($sformatf("v%0d_flush", i), 64'(flush), 64'(vecs[i].e_bt));
         check($sformatf("v%0d_tgt", i), branch_target, vecs[i].tgt);
         tick();
         check($sformatf("v%0d_mw_rw", i), 64'(MW_RegWrite), 64'(vecs[i].e_rw));
         check($sformatf("v%0d_mw_mtr", i), 64'(MW_MemtoReg), 64'(vecs[i].e_mtr));
         check($sformatf("v%0d_mw_rd", i), 64'(MW_RD), 64'(vecs[i].e_rd));
         check($sformatf("v%0d_mw_res", i), MW_Result, vecs[i].e_res);
         check($sformatf("v%0d_mw_rdata", i), MW_ReadData, 64'd0);
         check($sformatf("v%0d_req", i), 64'(dmem_bus.req), 64'd0);
         check($sformatf("v%0d_err", i), 64'(mem_err), 64'(vecs[i].e_err));
      end
      set_nop();
      do_reset();
      check("clr_err", 64'(mem_err), 64'd0);

      // Load, ack on the fourth BUSY cycle.
      drive(0, 1, 0, 1, 1, 0, 0, 5'd10, 64'h0, 64'h100, 64'h0);
      stall_cnt = 0;
      #1;
      if (stall) stall_cnt++;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("ld_req%0d", c), 64'(dmem_bus.req), 64'd1);
         check($sformatf("ld_addr%0d", c), dmem_bus.addr, 64'h100);
         check($sformatf("ld_we%0d", c), 64'(dmem_bus.we), 64'd0);
         check($sformatf("ld_bub%0d", c), 64'(MW_RegWrite), 64'd0);
         #1;
         if (stall) stall_cnt++;
      end
      tick();
      dmem_bus.ack   = 1'b1;
      dmem_bus.rdata = 64'hDEAD_BEEF;
      #1;
      if (stall) stall_cnt++;
      check("ld_stall_cycles", 64'(stall_cnt), 64'd4);
      tick();
      dmem_bus.ack = 1'b0;
      check("ld_rdata", MW_ReadData, 64'hDEAD_BEEF);
      check("ld_mtr", 64'(MW_MemtoReg), 64'd1);
      check("ld_rw", 64'(MW_RegWrite), 64'd1);
      check("ld_rd", 64'(MW_RD), 64'd10);
      check("ld_res", MW_Result, 64'h100);
      check("ld_req_done", 64'(dmem_bus.req), 64'd0);
      set_nop();

      // Store, ack on the first BUSY cycle.
      drive(0, 0, 1, 0, 0, 0, 0, 5'd0, 64'h0, 64'h108, 64'h55);
      #1;
      check("st_stall_idle", 64'(stall), 64'd1);
      tick();
      check("st_req", 64'(dmem_bus.req), 64'd1);
      check("st_we", 64'(dmem_bus.we), 64'd1);
      check("st_addr", dmem_bus.addr, 64'h108);
      check("st_wdata", dmem_bus.wdata, 64'h55);
      dmem_bus.ack   = 1'b1;
      dmem_bus.rdata = 64'h1111;
      #1;
      check("st_stall_ack", 64'(stall), 64'd0);
      tick();
      dmem_bus.ack = 1'b0;
      check("st_req_done", 64'(dmem_bus.req), 64'd0);
      check("st_rw", 64'(MW_RegWrite), 64'd0);
      check("st_rdata", MW_ReadData, 64'd0);
      check("st_err", 64'(mem_err), 64'd0);
      set_nop();

      // Load with no ack: aborts after TIMEOUT_CYCLES stalled cycles.
      drive(0, 1, 0, 1, 1, 0, 0, 5'd12, 64'h0, 64'h200, 64'h0);
      stall_cnt = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (stall) stall_cnt++;
         else done = 1'b1;
         if (!done) begin
            tick();
            check($sformatf("to_req%0d", c), 64'(dmem_bus.req), 64'd1);
         end
      end
      check("to_bound", 64'(done), 64'd1);
      check("to_stall_cycles", 64'(stall_cnt), 64'd16);
      tick();
      set_nop();
      check("to_err", 64'(mem_err), 64'd1);
      check("to_req_done", 64'(dmem_bus.req), 64'd0);
      check_mw_bubble("to");

      // Reset in the middle of an access, then a stray ack.
      drive(0, 1, 0, 1, 1, 0, 0, 5'd14, 64'h0, 64'h300, 64'h0);
      tick();
      check("rb_req", 64'(dmem_bus.req), 64'd1);
      reset = 1'b0;
      set_nop();
      tick();
      reset = 1'b1;
      check("rb_req_clr", 64'(dmem_bus.req), 64'd0);
      check("rb_err_clr", 64'(mem_err), 64'd0);
      check_mw_bubble("rb");
      drive(0, 0, 0, 0, 1, 0, 0, 5'd6, 64'h0, 64'h58, 64'h0);
      dmem_bus.ack   = 1'b1;
      dmem_bus.rdata = 64'h1234;
      #1;
      check("stray_stall", 64'(stall), 64'd0);
      tick();
      dmem_bus.ack = 1'b0;
      check("stray_rdata", MW_ReadData, 64'd0);
      check("stray_rw", 64'(MW_RegWrite), 64'd1);
      check("stray_rd", 64'(MW_RD), 64'd6);
      check("stray_res", MW_Result, 64'h58);
      check("stray_req", 64'(dmem_bus.req), 64'd0);
      set_nop();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
